// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Opcode type and opcode constants shared by the ALU pipeline,
//               its combinational core, its bus interface and the bench.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t OP_AND = 3'b000;
    localparam alu_op_t OP_OR  = 3'b001;
    localparam alu_op_t OP_ADD = 3'b010;
    localparam alu_op_t OP_XOR = 3'b011;
    localparam alu_op_t OP_NOR = 3'b100;
    localparam alu_op_t OP_SLL = 3'b101;
    localparam alu_op_t OP_SUB = 3'b110;
    localparam alu_op_t OP_SLT = 3'b111;

endpackage
`default_nettype wire

// File: rtl/alu_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe_if
// Description : Request/response bus of the ALU pipeline.
//               Request  : i_ul_a, i_ul_b, i_u3_sel, i_b_valid / o_b_ready
//               Response : o_ul_r, flags (Z,N,C,V), o_b_valid / i_b_ready
//               master = requester/consumer, slave = the ALU pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_pipe_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] i_ul_a;
    logic [WIDTH-1:0] i_ul_b;
    alu_op_t          i_u3_sel;
    logic             i_b_valid;
    logic             o_b_ready;
    logic [WIDTH-1:0] o_ul_r;
    logic             o_b_valid;
    logic             i_b_ready;
    logic             o_bi_zflag;
    logic             o_b_nflag;
    logic             o_b_cflag;
    logic             o_b_vflag;

    modport master (
        output i_ul_a, i_ul_b, i_u3_sel, i_b_valid, i_b_ready,
        input  o_b_ready, o_ul_r, o_b_valid,
               o_bi_zflag, o_b_nflag, o_b_cflag, o_b_vflag
    );

    modport slave (
        input  i_ul_a, i_ul_b, i_u3_sel, i_b_valid, i_b_ready,
        output o_b_ready, o_ul_r, o_b_valid,
               o_bi_zflag, o_b_nflag, o_b_cflag, o_b_vflag
    );

endinterface
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_core
// Description : Purely combinational ALU datapath.
//   i_a, i_b  : operands (WIDTH)
//   i_op      : opcode (alu_op_t)
//   o_result  : result (WIDTH)
//   o_carry   : carry-out for ADD, no-borrow for SUB/SLT, else 0
//   o_ovf     : signed overflow for ADD/SUB, else 0
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit SLT_SIGNED = 1'b1
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  alu_op_t          i_op,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry,
    output logic             o_ovf
);

    localparam int c_SHIFT_W = $clog2(WIDTH);
    localparam int c_MSB     = WIDTH - 1;

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;
    logic           w_add_ovf;
    logic           w_sub_ovf;
    logic           w_lt;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    // Subtraction as a + ~b + 1 so bit WIDTH is the no-borrow flag.
    assign w_diff = {1'b0, i_a} + {1'b0, ~i_b} + {{WIDTH{1'b0}}, 1'b1};

    assign w_add_ovf = (i_a[c_MSB] == i_b[c_MSB]) & (w_sum[c_MSB]  != i_a[c_MSB]);
    assign w_sub_ovf = (i_a[c_MSB] != i_b[c_MSB]) & (w_diff[c_MSB] != i_a[c_MSB]);

    // Signed less-than is the true sign of a-b (sign xor overflow);
    // unsigned less-than is a borrow out of a-b.
    assign w_lt = SLT_SIGNED ? (w_diff[c_MSB] ^ w_sub_ovf) : ~w_diff[WIDTH];

    always_comb begin
        o_result = '0;
        o_carry  = 1'b0;
        o_ovf    = 1'b0;
        case (i_op)
            OP_AND: o_result = i_a & i_b;
            OP_OR:  o_result = i_a | i_b;
            OP_XOR: o_result = i_a ^ i_b;
            OP_NOR: o_result = ~(i_a | i_b);
            OP_ADD: begin
                o_result = w_sum[c_MSB:0];
                o_carry  = w_sum[WIDTH];
                o_ovf    = w_add_ovf;
            end
            OP_SUB: begin
                o_result = w_diff[c_MSB:0];
                o_carry  = w_diff[WIDTH];
                o_ovf    = w_sub_ovf;
            end
            OP_SLL: o_result = i_a << i_b[c_SHIFT_W-1:0];
            OP_SLT: begin
                o_result = {{(WIDTH-1){1'b0}}, w_lt};
                o_carry  = w_diff[WIDTH];
            end
            default: o_result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe
// Description : Two-stage valid/ready ALU pipeline around alu_core.
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_pipe_if slave (operands/opcode in, result/flags out)
//   Stage 1 registers operands and opcode; stage 2 registers result and
//   Z/N/C/V flags. Accept-to-valid latency is two cycles, throughput one
//   operation per cycle while the consumer is ready.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit SLT_SIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_pipe_if.slave   bus
);

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    alu_op_t          r_s1_op;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_r;
    logic             r_s2_z;
    logic             r_s2_n;
    logic             r_s2_c;
    logic             r_s2_v;

    logic             w_s1_adv;
    logic             w_s1_load;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_ovf;

    // S1 may move into S2 whenever S2 is empty or being drained this cycle,
    // so output and S1->S2 move happen together without a bubble.
    assign w_s1_adv  = ~r_s2_valid | bus.i_b_ready;
    assign w_s1_load = ~r_s1_valid | w_s1_adv;

    // Reset is folded into ready only at the port so no request is
    // advertised as accepted while the block is held in reset.
    assign bus.o_b_ready = w_s1_load & rst_n;

    alu_core #(
        .WIDTH      (WIDTH),
        .SLT_SIGNED (SLT_SIGNED)
    ) u_core (
        .i_a      (r_s1_a),
        .i_b      (r_s1_b),
        .i_op     (r_s1_op),
        .o_result (w_res),
        .o_carry  (w_carry),
        .o_ovf    (w_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_op    <= OP_AND;
        end else if (w_s1_load) begin
            r_s1_valid <= bus.i_b_valid;
            if (bus.i_b_valid) begin
                r_s1_a  <= bus.i_ul_a;
                r_s1_b  <= bus.i_ul_b;
                r_s1_op <= bus.i_u3_sel;
            end
        end
    end

    // Result and flags only change when a new operation lands in S2, so
    // they stay stable for as long as the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_r     <= '0;
            r_s2_z     <= 1'b0;
            r_s2_n     <= 1'b0;
            r_s2_c     <= 1'b0;
            r_s2_v     <= 1'b0;
        end else if (w_s1_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_r <= w_res;
                r_s2_z <= (w_res == '0);
                r_s2_n <= w_res[WIDTH-1];
                r_s2_c <= w_carry;
                r_s2_v <= w_ovf;
            end
        end
    end

    assign bus.o_b_valid  = r_s2_valid;
    assign bus.o_ul_r     = r_s2_r;
    assign bus.o_bi_zflag = r_s2_z;
    assign bus.o_b_nflag  = r_s2_n;
    assign bus.o_b_cflag  = r_s2_c;
    assign bus.o_b_vflag  = r_s2_v;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_pipe
// Description : Self-checking bench for alu_pipe. Three instances:
//               bs = WIDTH 32 signed SLT, bu = WIDTH 32 unsigned SLT,
//               bh = WIDTH 16 signed SLT (randomised traffic).
//               Expected results are queued on accept and popped on output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;
    import alu_pkg::*;

    typedef struct packed {
        logic [63:0] r;
        logic        z;
        logic        n;
        logic        c;
        logic        v;
    } res_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_tests;
    int   n_fail;

    res_t sb      [3][$];
    res_t obs_log [2][$];
    int   n_out   [3];
    int   n_acc_h;
    int   acc_cyc [$];
    int   out_cyc [$];

    alu_pipe_if #(.WIDTH(32)) bs ();
    alu_pipe_if #(.WIDTH(32)) bu ();
    alu_pipe_if #(.WIDTH(16)) bh ();

    alu_pipe #(.WIDTH(32), .SLT_SIGNED(1'b1)) u_dut_s (.clk(clk), .rst_n(rst_n), .bus(bs));
    alu_pipe #(.WIDTH(32), .SLT_SIGNED(1'b0)) u_dut_u (.clk(clk), .rst_n(rst_n), .bus(bu));
    alu_pipe #(.WIDTH(16), .SLT_SIGNED(1'b1)) u_dut_h (.clk(clk), .rst_n(rst_n), .bus(bh));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    // Reference model written from the arithmetic definitions.
    function automatic res_t model(int w, bit sgn, logic [63:0] a_in, logic [63:0] b_in, logic [2:0] op);
        logic [63:0] mask;
        logic [63:0] a;
        logic [63:0] b;
        logic [64:0] t;
        longint      sa;
        longint      sb_;
        longint      sr;
        longint      smax;
        longint      smin;
        res_t        o;
        mask = (64'd1 << w) - 64'd1;
        a    = a_in & mask;
        b    = b_in & mask;
        sa   = longint'(a);
        sb_  = longint'(b);
        if (a[w-1]) sa  = sa  - (longint'(1) << w);
        if (b[w-1]) sb_ = sb_ - (longint'(1) << w);
        smax = (longint'(1) << (w-1)) - 1;
        smin = -(longint'(1) << (w-1));
        o    = '0;
        case (op)
            OP_AND: o.r = a & b;
            OP_OR:  o.r = a | b;
            OP_XOR: o.r = a ^ b;
            OP_NOR: o.r = ~(a | b) & mask;
            OP_ADD: begin
                t   = {1'b0, a} + {1'b0, b};
                o.r = t[63:0] & mask;
                o.c = t[w];
                sr  = sa + sb_;
                o.v = (sr > smax) || (sr < smin);
            end
            OP_SUB: begin
                t   = {1'b0, a} + {1'b0, ~b & mask} + 65'd1;
                o.r = t[63:0] & mask;
                o.c = t[w];
                sr  = sa - sb_;
                o.v = (sr > smax) || (sr < smin);
            end
            OP_SLL: o.r = (a << (b % w)) & mask;
            default: begin
                o.r = sgn ? {63'd0, (sa < sb_)} : {63'd0, (a < b)};
                o.c = (a >= b);
            end
        endcase
        o.z = (o.r == 64'd0);
        o.n = o.r[w-1];
        return o;
    endfunction

    function automatic res_t mk(logic [63:0] r, logic z, logic n, logic c, logic v);
        res_t o;
        o.r = r; o.z = z; o.n = n; o.c = c; o.v = v;
        return o;
    endfunction

    task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic score(input int idx, input res_t o);
        res_t e;
        n_out[idx]++;
        if (idx < 2) obs_log[idx].push_back(o);
        check($sformatf("sb%0d_nonempty", idx), 68'(sb[idx].size() != 0), 68'd1);
        if (sb[idx].size() != 0) begin
            e = sb[idx].pop_front();
            check($sformatf("sb%0d_result", idx), o, e);
        end
    endtask

    // Handshakes are sampled on the falling edge: inputs change just after
    // the rising edge, so what is seen here is what the next edge samples.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bs.i_b_valid && bs.o_b_ready) begin
                sb[0].push_back(model(32, 1'b1, 64'(bs.i_ul_a), 64'(bs.i_ul_b), bs.i_u3_sel));
                acc_cyc.push_back(cyc);
            end
            if (bs.o_b_valid && bs.i_b_ready) begin
                score(0, mk(64'(bs.o_ul_r), bs.o_bi_zflag, bs.o_b_nflag, bs.o_b_cflag, bs.o_b_vflag));
                out_cyc.push_back(cyc);
            end
            if (bu.i_b_valid && bu.o_b_ready)
                sb[1].push_back(model(32, 1'b0, 64'(bu.i_ul_a), 64'(bu.i_ul_b), bu.i_u3_sel));
            if (bu.o_b_valid && bu.i_b_ready)
                score(1, mk(64'(bu.o_ul_r), bu.o_bi_zflag, bu.o_b_nflag, bu.o_b_cflag, bu.o_b_vflag));
            if (bh.i_b_valid && bh.o_b_ready) begin
                sb[2].push_back(model(16, 1'b1, 64'(bh.i_ul_a), 64'(bh.i_ul_b), bh.i_u3_sel));
                n_acc_h++;
            end
            if (bh.o_b_valid && bh.i_b_ready)
                score(2, mk(64'(bh.o_ul_r), bh.o_bi_zflag, bh.o_b_nflag, bh.o_b_cflag, bh.o_b_vflag));
        end
    end

    task automatic set_req(input int idx, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (idx == 0) begin
            bs.i_b_valid = 1'b1; bs.i_u3_sel = op; bs.i_ul_a = a; bs.i_ul_b = b;
        end else begin
            bu.i_b_valid = 1'b1; bu.i_u3_sel = op; bu.i_ul_a = a; bu.i_ul_b = b;
        end
    endtask

    // Offer a request and return just after the edge that accepted it;
    // valid is left high so consecutive calls are back-to-back.
    task automatic send(input int idx, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int k;
        logic rdy;
        set_req(idx, op, a, b);
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            rdy = (idx == 0) ? bs.o_b_ready : bu.o_b_ready;
            if (rdy) break;
        end
        check("send_accept", 68'(k < 50), 68'd1);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int idx);
        if (idx == 0) bs.i_b_valid = 1'b0;
        else          bu.i_b_valid = 1'b0;
    endtask

    task automatic wait_drain(input int idx);
        int k;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (sb[idx].size() == 0) break;
        end
        check($sformatf("drain%0d", idx), 68'(sb[idx].size()), 68'd0);
        @(posedge clk); #1;
    endtask

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            4:       return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    localparam logic [31:0] c_A = 32'h0C041820;
    localparam logic [31:0] c_B = 32'h24208100;

    initial begin
        res_t        held;
        bit          have;
        bit          took;
        int          acc;
        int          ri;
        logic [2:0]  rop [4];
        logic [31:0] ra  [4];
        logic [31:0] rb  [4];

        rop = '{OP_XOR, OP_NOR, OP_SUB, OP_ADD};
        ra  = '{32'h1234_5678, 32'h0F0F_0000, 32'h0000_0005, 32'h8000_0000};
        rb  = '{32'hFFFF_0000, 32'h00F0_F0F0, 32'h0000_0007, 32'h8000_0000};

        n_tests = 0; n_fail = 0; cyc = 0; n_acc_h = 0;
        n_out = '{0, 0, 0};
        rst_n = 1'b0;
        bs.i_b_valid = 0; bs.i_ul_a = '0; bs.i_ul_b = '0; bs.i_u3_sel = OP_AND; bs.i_b_ready = 1'b1;
        bu.i_b_valid = 0; bu.i_ul_a = '0; bu.i_ul_b = '0; bu.i_u3_sel = OP_AND; bu.i_b_ready = 1'b1;
        bh.i_b_valid = 0; bh.i_ul_a = '0; bh.i_ul_b = '0; bh.i_u3_sel = OP_AND; bh.i_b_ready = 1'b1;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 68'(bs.o_b_valid), 68'd0);
        check("rst_ready", 68'(bs.o_b_ready), 68'd0);
        check("rst_outs",  mk(64'(bs.o_ul_r), bs.o_bi_zflag, bs.o_b_nflag, bs.o_b_cflag, bs.o_b_vflag), 68'd0);
        check("rst_h_valid", 68'(bh.o_b_valid), 68'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_ready", 68'(bs.o_b_ready), 68'd1);
        @(posedge clk); #1;

        // ---------------- back-to-back AND/OR/ADD/SUB ----------------
        obs_log[0].delete(); acc_cyc.delete(); out_cyc.delete();
        send(0, OP_AND, c_A, c_B);
        send(0, OP_OR,  c_A, c_B);
        send(0, OP_ADD, c_A, c_B);
        send(0, OP_SUB, c_A, c_B);
        idle(0);
        wait_drain(0);
        check("b2b_count", 68'(obs_log[0].size()), 68'd4);
        if (obs_log[0].size() == 4 && out_cyc.size() == 4 && acc_cyc.size() == 4) begin
            check("b2b_and", obs_log[0][0], mk(64'h04000000, 0, 0, 0, 0));
            check("b2b_or",  obs_log[0][1], mk(64'h2C249920, 0, 0, 0, 0));
            check("b2b_add", obs_log[0][2], mk(64'h30249920, 0, 0, 0, 0));
            check("b2b_sub", obs_log[0][3], mk(64'hE7E39720, 0, 1, 0, 0));
            check("latency", 68'(out_cyc[0] - acc_cyc[0]), 68'd2);
            for (int i = 1; i < 4; i++)
                check($sformatf("throughput%0d", i), 68'(out_cyc[i] - out_cyc[0]), 68'(i));
        end

        // ---------------- flag boundaries, SLL, SLT ----------------
        obs_log[0].delete(); obs_log[1].delete();
        send(0, OP_ADD, 32'h7FFFFFFF, 32'h00000001);
        send(0, OP_ADD, 32'hFFFFFFFF, 32'h00000001);
        send(0, OP_SLL, 32'h00000001, 32'd31);
        send(0, OP_SLT, 32'hFFFFFFFF, 32'h00000001);
        idle(0);
        send(1, OP_SLT, 32'hFFFFFFFF, 32'h00000001);
        idle(1);
        wait_drain(0);
        wait_drain(1);
        check("bnd_count", 68'(obs_log[0].size()), 68'd4);
        check("sltu_count", 68'(obs_log[1].size()), 68'd1);
        if (obs_log[0].size() == 4) begin
            check("add_ovf",  obs_log[0][0], mk(64'h80000000, 0, 1, 0, 1));
            check("add_wrap", obs_log[0][1], mk(64'h00000000, 1, 0, 1, 0));
            check("sll_31",   obs_log[0][2], mk(64'h80000000, 0, 1, 0, 0));
            check("slt_sgn",  obs_log[0][3], mk(64'h00000001, 0, 0, 1, 0));
        end
        if (obs_log[1].size() == 1)
            check("slt_uns", obs_log[1][0], mk(64'h00000000, 1, 0, 1, 0));

        // ---------------- stall with 4 requests offered ----------------
        obs_log[0].delete();
        bs.i_b_ready = 1'b0;
        ri = 0; acc = 0; have = 0;
        set_req(0, rop[0], ra[0], rb[0]);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("stall_ready%0d", c), 68'(bs.o_b_ready), 68'(c < 2));
            if (bs.o_b_valid) begin
                if (!have) begin
                    held = mk(64'(bs.o_ul_r), bs.o_bi_zflag, bs.o_b_nflag, bs.o_b_cflag, bs.o_b_vflag);
                    have = 1;
                end else begin
                    check("stall_hold",
                          mk(64'(bs.o_ul_r), bs.o_bi_zflag, bs.o_b_nflag, bs.o_b_cflag, bs.o_b_vflag), held);
                end
            end
            took = bs.o_b_ready;
            @(posedge clk); #1;
            if (took) begin
                acc++; ri++;
                set_req(0, rop[ri], ra[ri], rb[ri]);
            end
        end
        check("stall_accepts", 68'(acc), 68'd2);
        check("stall_seen", 68'(have), 68'd1);
        bs.i_b_ready = 1'b1;
        for (int i = ri; i < 4; i++) send(0, rop[i], ra[i], rb[i]);
        idle(0);
        wait_drain(0);
        check("stall_out_count", 68'(obs_log[0].size()), 68'd4);

        // ---------------- reset with both stages full ----------------
        bs.i_b_ready = 1'b0;
        send(0, OP_OR, 32'h0000_00F0, 32'h0000_000F);
        send(0, OP_ADD, 32'h0000_0010, 32'h0000_0020);
        idle(0);
        @(negedge clk);
        check("prerst_valid", 68'(bs.o_b_valid), 68'd1);
        check("prerst_ready", 68'(bs.o_b_ready), 68'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 68'(bs.o_b_valid), 68'd0);
        check("midrst_ready", 68'(bs.o_b_ready), 68'd0);
        check("midrst_outs",  mk(64'(bs.o_ul_r), bs.o_bi_zflag, bs.o_b_nflag, bs.o_b_cflag, bs.o_b_vflag), 68'd0);
        sb[0].delete(); sb[1].delete(); sb[2].delete();
        obs_log[0].delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel2_ready", 68'(bs.o_b_ready), 68'd1);
        bs.i_b_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("no_stale", 68'(obs_log[0].size()), 68'd0);

        // ---------------- random traffic, WIDTH 16 ----------------
        n_out[2] = 0; n_acc_h = 0; took = 0;
        for (int c = 0; c < 60000; c++) begin
            @(posedge clk); #1;
            if (n_acc_h >= 10000) break;
            if (took || !bh.i_b_valid) begin
                bh.i_b_valid = ($urandom_range(0, 3) != 0);
                bh.i_ul_a    = rnd16();
                bh.i_ul_b    = rnd16();
                bh.i_u3_sel  = alu_op_t'($urandom_range(0, 7));
            end
            bh.i_b_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            took = bh.i_b_valid && bh.o_b_ready;
        end
        bh.i_b_valid = 1'b0;
        bh.i_b_ready = 1'b1;
        wait_drain(2);
        check("rand_accepts", 68'(n_acc_h), 68'd10000);
        check("rand_outputs", 68'(n_out[2]), 68'd10000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (legal 8..64).
REQ-002 SHALL have parameter SLT_SIGNED, default 1; 1 means SLT compares signed, 0 means unsigned.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_ul_a  input  WIDTH  operand A.
REQ-006 SHALL have port i_ul_b  input  WIDTH  operand B; low $clog2(WIDTH) bits are the shift amount for SLL.
REQ-007 SHALL have port i_u3_sel  input  3  opcode.
REQ-008 SHALL have port i_b_valid  input  1  request valid.
REQ-009 SHALL have port o_b_ready  output  1  block accepts the request this cycle.
REQ-010 SHALL have port o_ul_r  output  WIDTH  result.
REQ-011 SHALL have port o_b_valid  output  1  result valid.
REQ-012 SHALL have port i_b_ready  input  1  downstream accepts the result.
REQ-013 SHALL have port o_bi_zflag  output  1  result == 0.
REQ-014 SHALL have port o_b_nflag  output  1  result MSB.
REQ-015 SHALL have port o_b_cflag  output  1  carry-out (ADD) / no-borrow (SUB, SLT); 0 for all other ops.
REQ-016 SHALL have port o_b_vflag  output  1  signed overflow (ADD, SUB); 0 for all other ops.

Function
REQ-017 Opcodes SHALL be: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 101 SLL, 110 SUB, 111 SLT.
REQ-018 SUB SHALL compute a + ~b + 1 in WIDTH+1 bits; C is the bit WIDTH carry-out.
REQ-019 SLT SHALL return 1 (zero-extended) when a < b under the SLT_SIGNED rule, else 0; V = 0.
REQ-020 SLL SHALL shift A left by b[$clog2(WIDTH)-1:0] and zero-fill.
REQ-021 Pipeline SHALL have two register stages: S1 captures operands+opcode; S2 captures result+flags.
REQ-022 Latency from accept (i_b_valid & o_b_ready) to o_b_valid SHALL be exactly 2 cycles when unstalled.
REQ-023 Throughput SHALL be one operation per cycle when i_b_ready stays high.
REQ-024 A transfer SHALL occur only on valid & ready of the same interface, in the same cycle.
REQ-025 o_b_ready SHALL equal (!S1.valid | S1 advancing), where S1 advances when (!S2.valid | i_b_ready).
REQ-026 While o_b_valid=1 and i_b_ready=0, o_ul_r and all flags SHALL hold stable.
REQ-027 With S2 stalled and S1 full, o_b_ready SHALL be 0; no accepted request is dropped or duplicated.
REQ-028 Simultaneous S2 output and S1 to S2 move SHALL occur in one cycle without a bubble.
REQ-029 Results SHALL leave in acceptance order.

Reset
REQ-030 On rst_n=0, the block SHALL asynchronously clear both stage valid bits, o_ul_r, and all flags.
REQ-031 During reset, o_b_valid SHALL be 0, and o_b_ready SHALL be 0 while rst_n=0.
REQ-032 Reset asserted mid-operation SHALL discard in-flight operations; the first cycle after release has o_b_ready=1.

Structure
REQ-033 Opcode constants (OP_AND..OP_SLT) SHALL live in shared package alu_pkg with a 3-bit opcode typedef.
REQ-034 Combinational datapath SHALL be sub-module alu_core (WIDTH, SLT_SIGNED) that returns result and C/V; alu_pipe adds the registers and handshake only.

Verification (WIDTH=32, A=0x0C041820, B=0x24208100 unless noted)
REQ-035 Back-to-back AND, OR, ADD, SUB with i_b_ready=1 SHALL give 0x04000000, 0x2C249920, 0x30249920, and 0xE7E39720 (N=1, C=0) on consecutive cycles starting 2 cycles after the first accept.
REQ-036 ADD 0x7FFFFFFF+0x00000001 SHALL give 0x80000000, V=1, N=1, C=0; ADD 0xFFFFFFFF+1 SHALL give 0, Z=1, C=1, V=0.
REQ-037 SLT with A=0xFFFFFFFF, B=1 SHALL give 1 with SLT_SIGNED=1 and 0 with SLT_SIGNED=0; SLL with A=1, B=31 SHALL give 0x80000000.
REQ-038 Holding i_b_ready=0 for 5 cycles with 4 requests offered SHALL accept exactly 2 and hold o_ul_r stable; on release, all results SHALL appear in order with none lost.
REQ-039 Asserting rst_n=0 with both stages full SHALL clear o_b_valid immediately, and no stale result SHALL appear after release.
REQ-040 A random 10k-op run at WIDTH=16 with random valid/ready SHALL match the scoreboard model for result and all four flags.
